seq_1010_moore: RTL and testbench



---
 rtl/seq_1010_pkg.sv | 21 ++
 rtl/seq_1010_sync.sv | 23 ++
 rtl/seq_1010_moore.sv | 60 ++++++
 tb/tb_seq_1010_moore.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_1010_pkg.sv
// Shared types for the 1-0-1-0 Moore detector: state encoding and width.
package seq_1010_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1010 = 3'd4
  } state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  function automatic logic sync_stages_legal(input int unsigned n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/seq_1010_sync.sv
// Flop-chain input synchroniser with synchronous active-high reset to 0.
module seq_1010_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/seq_1010_moore.sv
// Moore detector for serial pattern 1-0-1-0 (overlapping) on i_btn.
// Define SEQ_1010_SYNC_EN to insert a SYNC_STAGES-deep synchroniser ahead of the FSM.
module seq_1010_moore
  import seq_1010_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_led
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("seq_1010_moore: SYNC_STAGES must be in 2..4");
  end

  logic   w_bit;
  state_t r_state;
  state_t w_next;

`ifdef SEQ_1010_SYNC_EN
  seq_1010_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_d    (i_btn),
    .o_q    (w_bit)
  );
`else
  assign w_bit = i_btn;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // o_led depends on r_state only, so there is no path from i_btn to the LED.
  always_comb begin
    w_next = IDLE;
    o_led  = 1'b0;
    unique case (r_state)
      IDLE:    w_next = w_bit ? S1   : IDLE;
      S1:      w_next = w_bit ? S1   : S10;
      S10:     w_next = w_bit ? S101 : IDLE;
      S101:    w_next = w_bit ? S1   : S1010;
      S1010: begin
        w_next = w_bit ? S101 : IDLE;
        o_led  = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_1010_moore.sv
// Self-checking bench for seq_1010_moore against a bit-history reference model.
module tb_seq_1010_moore;

  localparam int unsigned SYNC = 2;
`ifdef SEQ_1010_SYNC_EN
  localparam int unsigned LAT = SYNC;
`else
  localparam int unsigned LAT = 0;
`endif

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_btn   = 1'b0;
  logic o_led;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: bits the detector has consumed since reset, plus the input delay line.
  bit   seen[$];
  bit   pipe[$];
  logic g_obs[$];
  logic g_exp[$];

  seq_1010_moore #(.SYNC_STAGES(SYNC)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_btn  (i_btn),
    .o_led  (o_led)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic model_led();
    int n = seen.size();
    if (n < 4) return 1'b0;
    return (seen[n-4] == 1'b1) && (seen[n-3] == 1'b0) &&
           (seen[n-2] == 1'b1) && (seen[n-1] == 1'b0);
  endfunction

  task automatic step(input bit b, input bit r);
    bit fb;
    @(negedge i_clock);
    i_btn   = b;
    i_reset = r;
    @(posedge i_clock);
    #1;
    if (r) begin
      seen.delete();
      pipe.delete();
      for (int unsigned k = 0; k < LAT; k++) pipe.push_back(1'b0);
    end else begin
      if (LAT == 0) begin
        fb = b;
      end else begin
        pipe.push_back(b);
        fb = pipe.pop_front();
      end
      seen.push_back(fb);
      if (seen.size() > 16) void'(seen.pop_front());
    end
    g_obs.push_back(o_led);
    g_exp.push_back(model_led());
  endtask

  // Reset, then bits MSB-first, then LAT+2 trailing zeros.
  task automatic run_seq(input logic [15:0] bits, input int len);
    g_obs.delete();
    g_exp.delete();
    step(1'b0, 1'b1);
    for (int i = 0; i < len; i++) step(bits[len-1-i], 1'b0);
    for (int unsigned i = 0; i < LAT + 2; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    g_obs.delete();
    g_exp.delete();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (g_obs[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold cycle %0d: o_led=%b expected 0", i, g_obs[i]);
      end
    end
    g_obs.delete();
    g_exp.delete();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int unsigned i = 0; i < LAT + 2; i++) step(1'b0, 1'b0);
    foreach (g_obs[i]) begin
      n_checks++;
      if (g_obs[i] !== g_exp[i]) begin
        n_errors++;
        $display("FAIL reset_release step %0d: o_led=%b expected %b", i, g_obs[i], g_exp[i]);
      end
    end
  endtask

  task automatic test_single_match();
    int pulses = 0;
    int first  = -1;
    run_seq(16'b1010, 4);
    foreach (g_obs[i]) begin
      n_checks++;
      if (g_obs[i] !== g_exp[i]) begin
        n_errors++;
        $display("FAIL single_match step %0d: o_led=%b expected %b", i, g_obs[i], g_exp[i]);
      end
      if (g_obs[i] === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_errors++;
      $display("FAIL single_match_count: pulses=%0d expected 1", pulses);
    end
    // Index 0 is the reset step; the 4th data edge is index 4.
    n_checks++;
    if (first !== 4 + int'(LAT)) begin
      n_errors++;
      $display("FAIL single_match_latency: first pulse at %0d expected %0d", first, 4 + LAT);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int p0 = -1;
    int p1 = -1;
    run_seq(16'b101010, 6);
    foreach (g_obs[i]) begin
      n_checks++;
      if (g_obs[i] !== g_exp[i]) begin
        n_errors++;
        $display("FAIL overlap step %0d: o_led=%b expected %b", i, g_obs[i], g_exp[i]);
      end
      if (g_obs[i] === 1'b1) begin
        if (pulses == 0) p0 = i;
        else if (pulses == 1) p1 = i;
        pulses++;
      end
    end
    n_checks++;
    if (pulses !== 2 || (p1 - p0) !== 2) begin
      n_errors++;
      $display("FAIL overlap_pulses: count=%0d gap=%0d expected 2 and 2", pulses, p1 - p0);
    end
  endtask

  task automatic test_near_miss();
    int pulses = 0;
    run_seq(16'b10010, 5);
    foreach (g_obs[i]) begin
      n_checks++;
      if (g_obs[i] !== g_exp[i]) begin
        n_errors++;
        $display("FAIL near_miss_10010 step %0d: o_led=%b expected %b", i, g_obs[i], g_exp[i]);
      end
      if (g_obs[i] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_errors++;
      $display("FAIL near_miss_10010_count: pulses=%0d expected 0", pulses);
    end
    pulses = 0;
    run_seq(16'b11010, 5);
    foreach (g_obs[i]) begin
      n_checks++;
      if (g_obs[i] !== g_exp[i]) begin
        n_errors++;
        $display("FAIL near_miss_11010 step %0d: o_led=%b expected %b", i, g_obs[i], g_exp[i]);
      end
      if (g_obs[i] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_errors++;
      $display("FAIL near_miss_11010_count: pulses=%0d expected 1", pulses);
    end
    pulses = 0;
    run_seq(16'b1100, 4);
    foreach (g_obs[i]) if (g_obs[i] === 1'b1) pulses++;
    n_checks++;
    if (pulses !== 0) begin
      n_errors++;
      $display("FAIL held_bits_1100_count: pulses=%0d expected 0", pulses);
    end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    logic [7:0] pat;
    g_obs.delete();
    g_exp.delete();
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int unsigned i = 0; i < LAT + 2; i++) step(1'b0, 1'b0);
    foreach (g_obs[i]) begin
      n_checks++;
      if (g_obs[i] !== g_exp[i]) begin
        n_errors++;
        $display("FAIL mid_reset step %0d: o_led=%b expected %b", i, g_obs[i], g_exp[i]);
      end
      if (g_obs[i] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_errors++;
      $display("FAIL mid_reset_count: pulses=%0d expected 0", pulses);
    end
    g_obs.delete();
    g_exp.delete();
    pulses = 0;
    pat = 8'b1010_0000;
    for (int i = 0; i < 4 + int'(LAT) + 2; i++) step((i < 8) ? pat[7-i] : 1'b0, 1'b0);
    foreach (g_obs[i]) if (g_obs[i] === 1'b1) pulses++;
    n_checks++;
    if (pulses !== 1) begin
      n_errors++;
      $display("FAIL mid_reset_follow_count: pulses=%0d expected 1", pulses);
    end
  endtask

  task automatic test_random();
    g_obs.delete();
    g_exp.delete();
    step(1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end
    foreach (g_obs[i]) begin
      n_checks++;
      if (g_obs[i] !== g_exp[i]) begin
        n_errors++;
        $display("FAIL random step %0d: o_led=%b expected %b", i, g_obs[i], g_exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_back_to_back();
    test_near_miss();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
